// File: rtl/cpu_pkg.sv
// Shared definitions for the small RISC core: opcode constants, the
// load-unit state type and the default datapath widths.
package cpu_pkg;

   // Default datapath widths used by the execution blocks.
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 4;

   // Opcode field values seen by decode.
   localparam logic [3:0] OP_ADDI = 4'h1;
   localparam logic [3:0] OP_LW   = 4'h4;
   localparam logic [3:0] OP_SW   = 4'h5;

   // Load-unit sequencing states.
   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      WB
   } ld_state_t;

   // Decode helper: true when the opcode selects a load word.
   function automatic logic is_load(input logic [3:0] op);
      return (op == OP_LW);
   endfunction

endpackage

// File: rtl/ea_calc.sv
// Effective-address calculator: base plus sign-extended immediate,
// truncated to the memory address width (wraps modulo 2^ADDR_W).
// Purely combinational; shared by the load and store paths.
module ea_calc #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int OFF_W  = 4
) (
   input  logic [DATA_W-1:0] base_i,
   input  logic [OFF_W-1:0]  off_i,
   output logic [ADDR_W-1:0] addr_o
);

   logic [DATA_W-1:0] off_ext;
   logic [DATA_W-1:0] sum;
   logic              unused_sum_hi;

   // Sign-extend the immediate to the register width, then add.
   assign off_ext = DATA_W'($signed(off_i));
   assign sum     = base_i + off_ext;

   // Only the low address bits reach the memory; the rest are dropped.
   assign addr_o        = sum[ADDR_W-1:0];
   assign unused_sum_hi = &{1'b0, sum[DATA_W-1:ADDR_W]};

endmodule

// File: rtl/load_unit.sv
// Load-word execution block. Accepts an LW from decode, issues one read
// to data memory, waits (bounded by TIMEOUT) for read data and writes it
// back to the register file with a one-cycle strobe.
// Optional build macro LOAD_FWD_EN enables store-to-load forwarding from
// a store that hits the same address in the accept cycle.
module load_unit
   import cpu_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int REG_AW  = 3,
   parameter int OFF_W   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_req,
   input  logic [DATA_W-1:0] ld_base,
   input  logic [OFF_W-1:0]  ld_off,
   input  logic [REG_AW-1:0] ld_rd,
   output logic              ld_ready,
   output logic              ld_busy,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   input  logic              st_we,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [DATA_W-1:0] st_wdata,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              ld_err
);

   localparam int              CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   ld_state_t         state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [REG_AW-1:0] rd_q;
   logic [DATA_W-1:0] data_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              ld_ready_q;
   logic              ld_busy_q;
   logic              mem_rd_en_q;
   logic              rf_we_q;
   logic [REG_AW-1:0] rf_waddr_q;
   logic              ld_err_q;

   logic [ADDR_W-1:0] ea;
   logic              fwd_hit;

   ea_calc #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .OFF_W  (OFF_W)
   ) u_ea (
      .base_i (ld_base),
      .off_i  (ld_off),
      .addr_o (ea)
   );

`ifdef LOAD_FWD_EN
   // A store to the same address in the accept cycle supplies the data.
   assign fwd_hit = st_we && (st_addr == ea);
`else
   // Without forwarding every load goes through memory.
   logic unused_st;
   assign fwd_hit   = 1'b0;
   assign unused_st = &{1'b0, st_we, st_addr, st_wdata};
`endif

   // Load sequencer with registered outputs; strobes default low each cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rd_q        <= '0;
         data_q      <= '0;
         cnt_q       <= '0;
         ld_ready_q  <= 1'b1;
         ld_busy_q   <= 1'b0;
         mem_rd_en_q <= 1'b0;
         rf_we_q     <= 1'b0;
         rf_waddr_q  <= '0;
         ld_err_q    <= 1'b0;
      end else begin
         mem_rd_en_q <= 1'b0;
         rf_we_q     <= 1'b0;
         rf_waddr_q  <= '0;
         data_q      <= '0;
         ld_err_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ld_req) begin
                  rd_q       <= ld_rd;
                  ld_ready_q <= 1'b0;
                  ld_busy_q  <= 1'b1;
                  if (fwd_hit) begin
                     // Forwarded store data skips the memory round trip.
                     state_q    <= WB;
                     data_q     <= st_wdata;
                     rf_we_q    <= 1'b1;
                     rf_waddr_q <= ld_rd;
                  end else begin
                     state_q     <= REQ;
                     addr_q      <= ea;
                     mem_rd_en_q <= 1'b1;
                  end
               end
            end
            REQ: begin
               // Memory cannot answer within the strobe cycle, so rvalid is
               // not looked at here.
               cnt_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (mem_rvalid) begin
                  // Read data wins even on the last allowed wait cycle.
                  state_q    <= WB;
                  addr_q     <= '0;
                  data_q     <= mem_rdata;
                  rf_we_q    <= 1'b1;
                  rf_waddr_q <= rd_q;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     // Abort: flag the error and become ready again.
                     state_q    <= IDLE;
                     addr_q     <= '0;
                     ld_err_q   <= 1'b1;
                     ld_ready_q <= 1'b1;
                     ld_busy_q  <= 1'b0;
                  end
               end
            end
            WB: begin
               state_q    <= IDLE;
               ld_ready_q <= 1'b1;
               ld_busy_q  <= 1'b0;
            end
            default: begin
               state_q    <= IDLE;
               ld_ready_q <= 1'b1;
               ld_busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ld_ready  = ld_ready_q;
   assign ld_busy   = ld_busy_q;
   assign mem_rd_en = mem_rd_en_q;
   assign mem_addr  = addr_q;
   assign rf_we     = rf_we_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = data_q;
   assign ld_err    = ld_err_q;

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed loads against a
// transaction-level model of the expected reads and write-backs.
module tb_load_unit;

   localparam int TMO = 15;

   logic       clk;
   logic       rst;
   logic       ld_req;
   logic [7:0] ld_base;
   logic [3:0] ld_off;
   logic [2:0] ld_rd;
   logic       ld_ready;
   logic       ld_busy;
   logic       mem_rd_en;
   logic [3:0] mem_addr;
   logic [7:0] mem_rdata;
   logic       mem_rvalid;
   logic       st_we;
   logic [3:0] st_addr;
   logic [7:0] st_wdata;
   logic       rf_we;
   logic [2:0] rf_waddr;
   logic [7:0] rf_wdata;
   logic       ld_err;

   load_unit dut (
      .clk        (clk),
      .rst        (rst),
      .ld_req     (ld_req),
      .ld_base    (ld_base),
      .ld_off     (ld_off),
      .ld_rd      (ld_rd),
      .ld_ready   (ld_ready),
      .ld_busy    (ld_busy),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .st_we      (st_we),
      .st_addr    (st_addr),
      .st_wdata   (st_wdata),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .ld_err     (ld_err)
   );

   typedef struct {
      int rd;
      int data;
   } wb_t;

   int   n_vec = 0;
   int   n_miss = 0;
   int   cyc = 0;
   int   exp_rd[$];
   wb_t  exp_wb[$];
   logic [7:0] mem [16];
   int   mem_lat = 1;
   int   resp_cnt = 0;
   int   resp_addr = 0;
   int   cur_ea = 0;
   int   n_rd = 0, n_wb = 0, n_err = 0;
   int   last_wb_cyc = -1000, last_err_cyc = -1000;
   int   last_rd_addr = -1, last_wb_addr = -1, last_wb_data = -1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
      end
   endtask

   // Reference address rule: plain integer arithmetic, modulo 16.
   function automatic int model_ea(input logic [7:0] base, input logic [3:0] off);
      int s;
      s = int'(base) + int'($signed(off));
      return s & 15;
   endfunction

   // Data memory: answers each read strobe mem_lat cycles later (0 = never).
   initial begin
      mem_rvalid = 1'b0;
      mem_rdata  = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         mem_rvalid = 1'b0;
         mem_rdata  = 8'h00;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = mem[resp_addr];
            end
         end
         if (mem_rd_en && mem_lat > 0) begin
            resp_cnt  = mem_lat;
            resp_addr = int'(mem_addr);
         end
      end
   end

   // Per-cycle compare of DUT outputs against the expectation queues.
   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_ready", ld_ready, 1);
         chk("rst_busy", ld_busy, 0);
         chk("rst_rd_en", mem_rd_en, 0);
         chk("rst_rf_we", rf_we, 0);
         chk("rst_err", ld_err, 0);
         chk("rst_mem_addr", mem_addr, 0);
      end else begin
         chk("ready_vs_busy", ld_ready, !ld_busy);
         if (mem_rd_en) begin
            n_rd++;
            last_rd_addr = int'(mem_addr);
            if (exp_rd.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL unexpected_rd: mem_rd_en=1 addr=%0h with no read pending", mem_addr);
            end else begin
               chk("mem_addr", mem_addr, exp_rd.pop_front());
            end
         end else if (ld_busy && !rf_we) begin
            chk("mem_addr_hold", mem_addr, cur_ea);
         end
         if (rf_we) begin
            n_wb++;
            last_wb_cyc  = cyc;
            last_wb_addr = int'(rf_waddr);
            last_wb_data = int'(rf_wdata);
            if (exp_wb.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL unexpected_wb: rf_we=1 waddr=%0d wdata=%0h with none expected",
                        rf_waddr, rf_wdata);
            end else begin
               wb_t e;
               e = exp_wb.pop_front();
               chk("rf_waddr", rf_waddr, e.rd);
               chk("rf_wdata", rf_wdata, e.data);
            end
         end else begin
            chk("rf_waddr_idle", rf_waddr, 0);
            chk("rf_wdata_idle", rf_wdata, 0);
         end
         if (ld_err) begin
            n_err++;
            last_err_cyc = cyc;
         end
      end
   end

   // Wait (bounded) for the cycle in which the held request is accepted.
   task automatic accept_wait(output int acc);
      acc = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         #1;
         if (ld_ready) begin
            acc = cyc;
            break;
         end
      end
      if (acc < 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL accept_timeout: ld_ready=%0d required 1 within 60 cycles", ld_ready);
      end
   endtask

   // Wait (bounded) for ld_ready to return after an accept.
   task automatic done_wait(output int done);
      done = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #1;
         if (ld_ready) begin
            done = cyc;
            break;
         end
      end
      if (done < 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL done_timeout: ld_ready=%0d required 1 within 40 cycles", ld_ready);
      end
   endtask

   // One complete load with its expected outcome derived from the rules.
   task automatic do_load(input logic [7:0] base, input logic [3:0] off, input logic [2:0] rd,
                          input int lat, input logic st_en, input logic [3:0] st_a,
                          input logic [7:0] st_d);
      int   ea, acc, done, rd0, wb0, er0, exp_lat;
      logic fwd, to;
      ea  = model_ea(base, off);
      fwd = 1'b0;
`ifdef LOAD_FWD_EN
      fwd = st_en && (int'(st_a) == ea);
`endif
      to = !fwd && (lat == 0 || lat > TMO);
      if (!fwd) exp_rd.push_back(ea);
      if (!to) exp_wb.push_back('{int'(rd), fwd ? int'(st_d) : int'(mem[ea])});
      rd0 = n_rd; wb0 = n_wb; er0 = n_err;
      @(posedge clk);
      #1;
      mem_lat  = lat;
      ld_req   = 1'b1;
      ld_base  = base;
      ld_off   = off;
      ld_rd    = rd;
      st_we    = st_en;
      st_addr  = st_a;
      st_wdata = st_d;
      accept_wait(acc);
      cur_ea = ea;
      @(posedge clk);
      #1;
      ld_req = 1'b0;
      st_we  = 1'b0;
      done_wait(done);
      if (to) begin
         chk("err_cycle", last_err_cyc - acc, 2 + TMO);
         chk("err_count", n_err - er0, 1);
         chk("to_no_wb", n_wb - wb0, 0);
         chk("to_ready_cycle", done - acc, 2 + TMO);
      end else begin
         exp_lat = fwd ? 1 : lat + 2;
         chk("wb_latency", last_wb_cyc - acc, exp_lat);
         chk("ready_latency", done - acc, exp_lat + 1);
         chk("wb_count", n_wb - wb0, 1);
         chk("no_err", n_err - er0, 0);
      end
      chk("rd_en_count", n_rd - rd0, fwd ? 0 : 1);
      $display("load base=%02h off=%01h rd=%0d lat=%0d st=%0d ea=%01h fwd=%0d timeout=%0d",
               base, off, rd, lat, st_en, ea, fwd, to);
   endtask

   initial begin
      int acc_a, acc_b, done, rd0, wb0, er0;
      for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
      rst = 1'b1; ld_req = 1'b0; ld_base = 8'h00; ld_off = 4'h0; ld_rd = 3'd0;
      st_we = 1'b0; st_addr = 4'h0; st_wdata = 8'h00;
      #2 rst = 1'b0;
      #1;
      chk("reset_ld_ready", ld_ready, 1);
      chk("reset_ld_busy", ld_busy, 0);
      chk("reset_mem_rd_en", mem_rd_en, 0);
      chk("reset_mem_addr", mem_addr, 0);
      chk("reset_rf_we", rf_we, 0);
      chk("reset_rf_waddr", rf_waddr, 0);
      chk("reset_rf_wdata", rf_wdata, 0);
      chk("reset_ld_err", ld_err, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // Pin the address model with hand-computed values.
      chk("model_ea_basic", model_ea(8'h03, 4'h2), 5);
      chk("model_ea_neg", model_ea(8'h01, 4'hE), 15);
      chk("model_ea_wrap", model_ea(8'h0F, 4'h1), 0);

      // Basic load, memory answers two cycles after the strobe.
      do_load(8'h03, 4'h2, 3'd5, 2, 1'b0, 4'h0, 8'h00);
      chk("basic_addr", last_rd_addr, 5);
      chk("basic_waddr", last_wb_addr, 5);
      chk("basic_wdata", last_wb_data, 8'hA5);

      // Minimum-latency memory.
      do_load(8'h40, 4'h7, 3'd3, 1, 1'b0, 4'h0, 8'h00);

      // Negative offset and address wrap.
      do_load(8'h01, 4'hE, 3'd2, 1, 1'b0, 4'h0, 8'h00);
      chk("neg_off_addr", last_rd_addr, 15);
      do_load(8'h0F, 4'h1, 3'd7, 3, 1'b0, 4'h0, 8'h00);
      chk("wrap_addr", last_rd_addr, 0);
      chk("wrap_wdata", last_wb_data, 8'hA0);

      // Timeout: no answer, answer on the last wait cycle, answer too late.
      do_load(8'h22, 4'h0, 3'd4, 0, 1'b0, 4'h0, 8'h00);
      do_load(8'h22, 4'h1, 3'd4, TMO, 1'b0, 4'h0, 8'h00);
      chk("last_wait_wdata", last_wb_data, 8'hA3);
      do_load(8'h22, 4'h2, 3'd1, TMO + 1, 1'b0, 4'h0, 8'h00);

      // Busy rejection: second request held during WAIT, taken after WB.
      rd0 = n_rd;
      exp_rd.push_back(model_ea(8'h20, 4'h3));
      exp_rd.push_back(model_ea(8'h07, 4'hF));
      exp_wb.push_back('{1, int'(mem[3])});
      exp_wb.push_back('{6, int'(mem[6])});
      @(posedge clk);
      #1;
      mem_lat = 3; ld_req = 1'b1; ld_base = 8'h20; ld_off = 4'h3; ld_rd = 3'd1;
      accept_wait(acc_a);
      cur_ea = 3;
      @(posedge clk);
      #1;
      ld_base = 8'h07; ld_off = 4'hF; ld_rd = 3'd6;
      accept_wait(acc_b);
      chk("busy_first_wb_lat", last_wb_cyc - acc_a, 5);
      chk("b2b_accept_after_wb", acc_b - last_wb_cyc, 1);
      cur_ea = 6;
      @(posedge clk);
      #1;
      ld_req = 1'b0;
      done_wait(done);
      chk("busy_second_wb_lat", last_wb_cyc - acc_b, 5);
      chk("busy_rd_en_total", n_rd - rd0, 2);
      $display("busy-reject pair: first accepted cycle %0d, second cycle %0d", acc_a, acc_b);

      // Reset during WAIT drops the load; the late answer is ignored.
      wb0 = n_wb; er0 = n_err;
      exp_rd.push_back(model_ea(8'h10, 4'h9));
      @(posedge clk);
      #1;
      mem_lat = 6; ld_req = 1'b1; ld_base = 8'h10; ld_off = 4'h9; ld_rd = 3'd2;
      accept_wait(acc_a);
      cur_ea = 9;
      @(posedge clk);
      #1;
      ld_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("wait_addr_before_rst", mem_addr, 9);
      chk("wait_busy_before_rst", ld_busy, 1);
      rst = 1'b0;
      #1;
      chk("async_rst_ready", ld_ready, 1);
      chk("async_rst_busy", ld_busy, 0);
      chk("async_rst_addr", mem_addr, 0);
      chk("async_rst_rf_we", rf_we, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("rst_drop_no_wb", n_wb - wb0, 0);
      chk("rst_drop_no_err", n_err - er0, 0);
      $display("reset mid-load: load accepted cycle %0d dropped", acc_a);

      // Same-cycle store to the load address, then to a different address.
      do_load(8'h03, 4'h2, 3'd2, 2, 1'b1, 4'h5, 8'h3C);
      do_load(8'h03, 4'h2, 3'd3, 2, 1'b1, 4'h6, 8'h3C);
      chk("st_miss_wdata", last_wb_data, 8'hA5);

      // Plain load after everything else.
      do_load(8'hFF, 4'h8, 3'd0, 2, 1'b0, 4'h0, 8'h00);
      chk("final_addr", last_rd_addr, 7);

      repeat (2) @(posedge clk);
      #1;
      chk("exp_rd_drained", exp_rd.size(), 0);
      chk("exp_wb_drained", exp_wb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
